// File: rtl/vpx_cmd_tx.sv
// rtl/vpx_cmd_tx.sv - VPX-P2 command/ID link serial frame transmitter
//
// Takes one DATA_W-bit word over a valid/ready handshake and sends it
// MSB-first, two bits per symbol, each symbol held CLK_DIV clocks, framed
// by O_DVLD. Every frame is followed by GAP_CYC clocks with O_DVLD low.
//
// Optional build macro: VPX_TX_PARITY_EN appends one even-parity symbol
// {^word, ~^word} after the payload.
//
// Ports:
//   CLK        register bus clock, rising edge
//   RST        synchronous active-high reset
//   TX_DATA    word to send, sampled only on accept
//   TX_VALID   TX_DATA valid
//   TX_READY   block can accept a word (decoded from state)
//   O_DVLD     frame-valid strobe to the pin
//   O_DATA     symbol lanes, [1] carries the higher bit
//   BUSY       frame or gap in progress
//   FRAME_CNT  completed frame count, wraps

module vpx_cmd_tx #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic              O_DVLD,
  output logic [1:0]        O_DATA,
  output logic              BUSY,
  output logic [31:0]       FRAME_CNT
);

  localparam int NSYM  = DATA_W / 2;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SYM_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NSYM - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

`ifdef VPX_TX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_PAR   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic              dvld_q, dvld_d;
  logic [1:0]        odata_q, odata_d;
  logic              busy_q, busy_d;
`ifdef VPX_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // Gated with RST so the handshake is closed for the whole reset pulse,
  // including the cycle before the first reset edge.
  assign TX_READY  = (state_q == ST_IDLE) && !RST;
  assign O_DVLD    = dvld_q;
  assign O_DATA    = odata_q;
  assign BUSY      = busy_q;
  assign FRAME_CNT = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    div_d       = div_q;
    sym_d       = sym_q;
    gap_d       = gap_q;
    frame_cnt_d = frame_cnt_q;
`ifdef VPX_TX_PARITY_EN
    par_d       = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (TX_VALID) begin
          state_d = ST_SHIFT;
          sr_d    = TX_DATA;
          div_d   = '0;
          sym_d   = '0;
`ifdef VPX_TX_PARITY_EN
          par_d   = ^TX_DATA;
`endif
        end
      end

      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sr_d  = sr_q << 2;
          sym_d = sym_q + SYM_W'(1);
          if (sym_q == SYM_LAST) begin
`ifdef VPX_TX_PARITY_EN
            state_d = ST_PAR;
`else
            state_d     = ST_GAP;
            gap_d       = '0;
            frame_cnt_d = frame_cnt_q + 32'd1;
`endif
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

`ifdef VPX_TX_PARITY_EN
      ST_PAR: begin
        if (div_q == DIV_LAST) begin
          div_d       = '0;
          state_d     = ST_GAP;
          gap_d       = '0;
          frame_cnt_d = frame_cnt_q + 32'd1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
`endif

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin outputs are registered from the next-state values so the first
  // symbol appears on the cycle right after the accept edge.
  always_comb begin
    dvld_d  = 1'b0;
    odata_d = 2'b00;
    busy_d  = (state_d != ST_IDLE);
    if (state_d == ST_SHIFT) begin
      dvld_d  = 1'b1;
      odata_d = sr_d[DATA_W-1 -: 2];
    end
`ifdef VPX_TX_PARITY_EN
    if (state_d == ST_PAR) begin
      dvld_d  = 1'b1;
      odata_d = {par_d, ~par_d};
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      div_q       <= '0;
      sym_q       <= '0;
      gap_q       <= '0;
      frame_cnt_q <= '0;
      dvld_q      <= 1'b0;
      odata_q     <= 2'b00;
      busy_q      <= 1'b0;
`ifdef VPX_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      div_q       <= div_d;
      sym_q       <= sym_d;
      gap_q       <= gap_d;
      frame_cnt_q <= frame_cnt_d;
      dvld_q      <= dvld_d;
      odata_q     <= odata_d;
      busy_q      <= busy_d;
`ifdef VPX_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_vpx_cmd_tx.sv
// tb/tb_vpx_cmd_tx.sv - self-checking bench for vpx_cmd_tx (default and fast/wrap instances)

module tb_vpx_cmd_tx;

  logic        clk;
  logic        rst;
  logic [31:0] tx_data0, tx_data1;
  logic        tx_valid0, tx_valid1;
  logic        ready0, ready1;
  logic        dvld0, dvld1;
  logic [1:0]  odata0, odata1;
  logic        busy0, busy1;
  logic [31:0] fcnt0, fcnt1;

  int          checks;
  int          errors;
  logic [31:0] exp_cnt [2];

  vpx_cmd_tx dut0 (
    .CLK(clk), .RST(rst), .TX_DATA(tx_data0), .TX_VALID(tx_valid0),
    .TX_READY(ready0), .O_DVLD(dvld0), .O_DATA(odata0), .BUSY(busy0),
    .FRAME_CNT(fcnt0)
  );

  vpx_cmd_tx #(.DATA_W(32), .CLK_DIV(1), .GAP_CYC(1)) dut1 (
    .CLK(clk), .RST(rst), .TX_DATA(tx_data1), .TX_VALID(tx_valid1),
    .TX_READY(ready1), .O_DVLD(dvld1), .O_DATA(odata1), .BUSY(busy1),
    .FRAME_CNT(fcnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] data);
    if (d == 0) begin
      tx_valid0 = v;
      tx_data0  = data;
    end else begin
      tx_valid1 = v;
      tx_data1  = data;
    end
  endtask

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Idle-state checks on one instance at the current sample point.
  task automatic chk_idle(input int d, input string tag);
    if (d == 0) begin
      chk({tag, "_ready0"}, 32'(ready0), 32'd1);
      chk({tag, "_dvld0"},  32'(dvld0),  32'd0);
      chk({tag, "_data0"},  32'(odata0), 32'd0);
      chk({tag, "_busy0"},  32'(busy0),  32'd0);
      chk({tag, "_cnt0"},   fcnt0,       exp_cnt[0]);
    end else begin
      chk({tag, "_ready1"}, 32'(ready1), 32'd1);
      chk({tag, "_dvld1"},  32'(dvld1),  32'd0);
      chk({tag, "_data1"},  32'(odata1), 32'd0);
      chk({tag, "_busy1"},  32'(busy1),  32'd0);
      chk({tag, "_cnt1"},   fcnt1,       exp_cnt[1]);
    end
  endtask

  // Reference model: frame = 16 two-bit symbols taken MSB-first, each held
  // div cycles with DVLD high, optional parity symbol, then gap cycles
  // with DVLD low and the count already advanced. Entered at the sample
  // point of the first frame cycle; returns at the following IDLE cycle.
  task automatic expect_frame(input int d, input logic [31:0] word, input string tag);
    logic [1:0] sym;
    logic       dv;
    logic [1:0] od;
    logic       bz;
    logic       rdy;
    logic [31:0] fc;
    int         div;
    int         gap;
    int         high_cnt;
    div = div_of(d);
    gap = gap_of(d);
    high_cnt = 0;
    for (int s = 0; s < 16; s++) begin
      sym = 2'((word >> (30 - 2 * s)) & 32'd3);
      for (int k = 0; k < div; k++) begin
        dv = (d == 0) ? dvld0 : dvld1;
        od = (d == 0) ? odata0 : odata1;
        bz = (d == 0) ? busy0 : busy1;
        chk({tag, "_dvld"}, 32'(dv), 32'd1);
        chk({tag, "_sym"},  32'(od), 32'(sym));
        chk({tag, "_busy"}, 32'(bz), 32'd1);
        high_cnt++;
        @(negedge clk);
      end
    end
`ifdef VPX_TX_PARITY_EN
    sym = {^word, ~^word};
    for (int k = 0; k < div; k++) begin
      dv = (d == 0) ? dvld0 : dvld1;
      od = (d == 0) ? odata0 : odata1;
      chk({tag, "_par_dvld"}, 32'(dv), 32'd1);
      chk({tag, "_par_sym"},  32'(od), 32'(sym));
      high_cnt++;
      @(negedge clk);
    end
`endif
    exp_cnt[d] = exp_cnt[d] + 32'd1;
    for (int g = 0; g < gap; g++) begin
      dv = (d == 0) ? dvld0 : dvld1;
      od = (d == 0) ? odata0 : odata1;
      bz = (d == 0) ? busy0 : busy1;
      fc = (d == 0) ? fcnt0 : fcnt1;
      chk({tag, "_gap_dvld"}, 32'(dv), 32'd0);
      chk({tag, "_gap_data"}, 32'(od), 32'd0);
      chk({tag, "_gap_busy"}, 32'(bz), 32'd1);
      chk({tag, "_gap_cnt"},  fc,      exp_cnt[d]);
      @(negedge clk);
    end
    rdy = (d == 0) ? ready0 : ready1;
    bz  = (d == 0) ? busy0 : busy1;
    dv  = (d == 0) ? dvld0 : dvld1;
    chk({tag, "_end_ready"}, 32'(rdy), 32'd1);
    chk({tag, "_end_busy"},  32'(bz),  32'd0);
    chk({tag, "_end_dvld"},  32'(dv),  32'd0);
`ifdef VPX_TX_PARITY_EN
    chk({tag, "_high_len"}, 32'(high_cnt), 32'(17 * div));
`else
    chk({tag, "_high_len"}, 32'(high_cnt), 32'(16 * div));
`endif
  endtask

  // Present a word in IDLE, let the accept edge pass, then scramble
  // TX_DATA (must be ignored) and optionally drop TX_VALID.
  task automatic send(input int d, input logic [31:0] word, input logic keep_valid,
                      input logic [31:0] next_data);
    drive(d, 1'b1, word);
    @(posedge clk);
    @(negedge clk);
    drive(d, keep_valid, next_data);
  endtask

  initial begin
    logic [31:0] w;
    int          idle;
    checks     = 0;
    errors     = 0;
    exp_cnt[0] = 32'd0;
    exp_cnt[1] = 32'd0;
    rst        = 1'b1;
    tx_valid0  = 1'b0;
    tx_valid1  = 1'b0;
    tx_data0   = 32'd0;
    tx_data1   = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 32'(ready0), 32'd0);
    chk("rst_dvld0",  32'(dvld0),  32'd0);
    chk("rst_data0",  32'(odata0), 32'd0);
    chk("rst_busy0",  32'(busy0),  32'd0);
    chk("rst_cnt0",   fcnt0,       32'd0);
    chk("rst_ready1", 32'(ready1), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk_idle(0, "idle");
      chk_idle(1, "idle");
      @(negedge clk);
    end

    // Single word on default instance
    send(0, 32'hA5C30F96, 1'b0, 32'h12345678);
    expect_frame(0, 32'hA5C30F96, "single");

    // Back-to-back with TX_VALID held high
    send(0, 32'hFFFFFFFF, 1'b1, 32'h00000000);
    expect_frame(0, 32'hFFFFFFFF, "b2b_a");
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 32'hDEADBEEF);
    expect_frame(0, 32'h00000000, "b2b_b");
    chk("b2b_cnt", fcnt0, 32'd3);

    // Reset mid-frame
    send(0, $urandom, 1'b0, $urandom);
    repeat (19) @(negedge clk);
    chk("pre_rst_dvld", 32'(dvld0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dvld", 32'(dvld0), 32'd0);
    chk("midrst_data", 32'(odata0), 32'd0);
    chk("midrst_cnt",  fcnt0,       32'd0);
    chk("midrst_busy", 32'(busy0),  32'd0);
    rst = 1'b0;
    exp_cnt[0] = 32'd0;
    exp_cnt[1] = 32'd0;
    @(negedge clk);
    chk_idle(0, "post_rst");
    send(0, 32'h00000001, 1'b0, $urandom);
    expect_frame(0, 32'h00000001, "post_rst_frame");
    chk("post_rst_cnt", fcnt0, 32'd1);

    // Randomized words with random idle spacing on both instances
    for (int i = 0; i < 8; i++) begin
      int d;
      d = i % 2;
      w = $urandom;
      idle = $urandom_range(0, 3);
      repeat (idle) begin
        chk_idle(d, "rnd_idle");
        @(negedge clk);
      end
      send(d, w, 1'b0, $urandom);
      expect_frame(d, w, "rnd");
    end

    // FRAME_CNT wrap on fast instance
    force dut1.frame_cnt_q = 32'hFFFFFFFE;
    @(negedge clk);
    release dut1.frame_cnt_q;
    @(negedge clk);
    exp_cnt[1] = 32'hFFFFFFFE;
    chk("wrap_preload", fcnt1, 32'hFFFFFFFE);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      send(1, w, 1'b0, $urandom);
      expect_frame(1, w, "wrap");
    end
    chk("wrap_final", fcnt1, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
